rc5_key_expand: RTL

- Computes the RC5-16 expanded key table S[0:33] from a user key of 0–16 bytes and a round count.
- Implements the standard RC5 key schedule: P/Q table initialisation, then a 3·max(t,c) mixing pass.
- Sits directly upstream of the encrypt/decrypt round engine, which consumes `subkeys`.
- `valid` tells the controller when the engine may be started.

---
 rtl/rc5_pkg.sv | 18 +
 rtl/rotl.sv | 10 +
 rtl/rc5_key_expand.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/rc5_pkg.sv
// rc5_pkg: RC5-16 magic constants, table sizes and the key-expansion state encoding
// shared by the key expander, its controller and the bench.
package rc5_pkg;

    localparam logic [15:0] P16 = 16'hB7E1;
    localparam logic [15:0] Q16 = 16'h9E37;

    localparam int unsigned MAX_ROUNDS  = 16;
    localparam int unsigned NUM_SUBKEYS = 34;

    typedef enum logic [1:0] {
        StIdle,
        StInit,
        StMix,
        StDone
    } kx_state_e;

endpackage

// File: rtl/rotl.sv
// rotl: 16-bit rotate-left by a 4-bit amount (amount 0 passes data through).
module rotl (
    input  logic [15:0] data_i,
    input  logic [3:0]  n_i,
    output logic [15:0] data_o
);

    assign data_o = (data_i << n_i) | (data_i >> (5'd16 - {1'b0, n_i}));

endmodule

// File: rtl/rc5_key_expand.sv
// rc5_key_expand: RC5-16 key schedule producing S[0:33], one INIT entry or MIX step per cycle.
// Optional RC5_KEY_ROUND_CHECK_EN: reject out-of-range r/b with an err pulse instead of clamping.
module rc5_key_expand
    import rc5_pkg::*;
#(
    parameter int unsigned MAX_KEY_BYTES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [8*MAX_KEY_BYTES-1:0] key,
    input  logic [4:0]                 key_len,
    input  logic [4:0]                 num_rounds,
    output logic [15:0]                subkeys [0:NUM_SUBKEYS-1],
    output logic                       busy,
    output logic                       valid,
    output logic                       err
);

    localparam int unsigned CMax = MAX_KEY_BYTES / 2;
    localparam int unsigned LW   = $clog2(CMax);
    localparam logic [5:0]  MaxB = 6'(MAX_KEY_BYTES);
    localparam logic [4:0]  MaxR = 5'(MAX_ROUNDS);

    kx_state_e   r_state;
    logic [15:0] r_s   [0:NUM_SUBKEYS-1];
    logic [15:0] r_l   [0:CMax-1];
    logic [15:0] r_a, r_b;
    logic [5:0]  r_k, r_i, r_j, r_t, r_c;
    logic [6:0]  r_n, r_nlast;
    logic        r_busy, r_valid, r_err;

    logic [4:0]  w_r_eff;
    logic [5:0]  w_b_eff, w_t, w_c, w_tc;
    logic [6:0]  w_n_tot;
    logic        w_cfg_bad, w_accept;
    logic [15:0] w_l_load [0:CMax-1];
    logic [15:0] w_sum_a, w_a_new, w_ab, w_sum_b, w_b_new, w_init_val;

    always_comb begin
        w_r_eff = (num_rounds > MaxR) ? MaxR : num_rounds;
        w_b_eff = ({1'b0, key_len} > MaxB) ? MaxB : {1'b0, key_len};
        w_t     = {w_r_eff, 1'b0} + 6'd2;
        w_c     = (w_b_eff + 6'd1) >> 1;
        if (w_c == 6'd0) begin
            w_c = 6'd1;
        end
        w_tc    = (w_t > w_c) ? w_t : w_c;
        w_n_tot = {1'b0, w_tc} + {w_tc, 1'b0};
        // Bytes beyond the key length never reach L.
        for (int w = 0; w < CMax; w++) begin
            w_l_load[w] = key[16*w +: 16];
            if (6'(2 * w) >= w_b_eff) begin
                w_l_load[w][7:0] = 8'h00;
            end
            if (6'(2 * w + 1) >= w_b_eff) begin
                w_l_load[w][15:8] = 8'h00;
            end
        end
    end

`ifdef RC5_KEY_ROUND_CHECK_EN
    assign w_cfg_bad = (num_rounds > MaxR) || ({1'b0, key_len} > MaxB);
`else
    assign w_cfg_bad = 1'b0;
`endif

    // DONE only accepts once valid is up; its first cycle still counts as busy.
    assign w_accept = start && ((r_state == StIdle) || ((r_state == StDone) && r_valid));

    assign w_init_val = P16 + Q16 * {10'd0, r_k};
    assign w_sum_a    = r_s[r_i] + r_a + r_b;
    assign w_ab       = w_a_new + r_b;
    assign w_sum_b    = r_l[r_j[LW-1:0]] + w_ab;

    rotl u_rotl_a (
        .data_i (w_sum_a),
        .n_i    (4'd3),
        .data_o (w_a_new)
    );

    rotl u_rotl_b (
        .data_i (w_sum_b),
        .n_i    (w_ab[3:0]),
        .data_o (w_b_new)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            for (int x = 0; x < NUM_SUBKEYS; x++) begin
                r_s[x] <= '0;
            end
            for (int w = 0; w < CMax; w++) begin
                r_l[w] <= '0;
            end
            r_a     <= '0;
            r_b     <= '0;
            r_k     <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_t     <= '0;
            r_c     <= '0;
            r_n     <= '0;
            r_nlast <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            unique case (r_state)
                StIdle, StDone: begin
                    if (w_accept && w_cfg_bad) begin
                        r_err <= 1'b1;
                    end else if (w_accept) begin
                        for (int w = 0; w < CMax; w++) begin
                            r_l[w] <= w_l_load[w];
                        end
                        r_t     <= w_t;
                        r_c     <= w_c;
                        r_nlast <= w_n_tot - 7'd1;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b0;
                        r_state <= StInit;
                    end else if ((r_state == StDone) && !r_valid) begin
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                StInit: begin
                    for (int x = 0; x < NUM_SUBKEYS; x++) begin
                        if (6'(x) == r_k) begin
                            r_s[x] <= w_init_val;
                        end else if ((r_k == 6'd0) && (6'(x) >= r_t)) begin
                            r_s[x] <= '0;
                        end
                    end
                    if (r_k == r_t - 6'd1) begin
                        r_i     <= '0;
                        r_j     <= '0;
                        r_n     <= '0;
                        r_a     <= '0;
                        r_b     <= '0;
                        r_state <= StMix;
                    end else begin
                        r_k <= r_k + 6'd1;
                    end
                end
                StMix: begin
                    r_s[r_i]         <= w_a_new;
                    r_l[r_j[LW-1:0]] <= w_b_new;
                    r_a              <= w_a_new;
                    r_b              <= w_b_new;
                    r_i              <= (r_i + 6'd1 == r_t) ? 6'd0 : r_i + 6'd1;
                    r_j              <= (r_j + 6'd1 == r_c) ? 6'd0 : r_j + 6'd1;
                    if (r_n == r_nlast) begin
                        r_state <= StDone;
                    end else begin
                        r_n <= r_n + 7'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign subkeys = r_s;
    assign busy    = r_busy;
    assign valid   = r_valid;
    assign err     = r_err;

endmodule
